dmem_arbiter: RTL and testbench

Arbitrates the single-port data memory between the pipeline MEM stage and the program/debug loader port, and sequences every access through a configurable wait-state count. It drives `cpu_stall` to freeze the pipeline while a MEM-stage load or store is in flight. It sits between `mem_cycle` and the data memory array, replacing the direct MEM-to-memory connection.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_wait_ctr.sv | 43 ++++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_pkg: shared types and widths for the data-memory arbiter.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int WCNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    CPU = 1'b0,
    LD  = 1'b1
  } owner_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter_if: MEM-stage, loader and memory-array signal group.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface dmem_arbiter_if;
  import mips_pkg::*;

  logic              MemRead;
  logic              MemWrite;
  logic [WORD_W-1:0] Address;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              cpu_stall;
  logic              cpu_done;
  logic              cpu_err;

  logic              ld_req;
  logic              ld_we;
  logic [WORD_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_wdata;
  logic              ld_ack;
  logic [WORD_W-1:0] ld_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, cpu_stall, cpu_done, cpu_err,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, cpu_stall, cpu_done, cpu_err,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_wait_ctr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_wait_ctr: wait-state counter, flags the final access cycle. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dmem_wait_ctr
  import mips_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [WCNT_W-1:0] C_LAST_CNT = WCNT_W'(WAIT_CYCLES);

  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (clr_i) begin
      wcnt_d = '0;
    end else if (inc_i) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign last_o = (wcnt_q == C_LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter: CPU/loader arbiter and wait-state sequencer for    |
// | the single-port data memory.                          Rev 1.0    |
// +------------------------------------------------------------------+
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int WAIT_CYCLES    = 0,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] C_STREAK_MAX = 4'(MAX_CPU_STREAK);
  localparam logic [3:0] C_STREAK_SAT = 4'd15;

  arb_state_t        state_q;
  owner_t            owner_q;
  logic [3:0]        streak_q;
  logic              write_q;
  logic              bad_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] cpu_rdata_q;
  logic [WORD_W-1:0] ld_rdata_q;
  logic              cpu_done_q;
  logic              cpu_err_q;
  logic              ld_ack_q;

  logic w_cpu_req;
  logic w_ld_wins;
  logic w_in_access;
  logic w_last;
  logic w_acc_last;

  assign w_cpu_req   = bus.MemRead | bus.MemWrite;
  // Loader takes the slot when the CPU is absent or has used up its streak.
  assign w_ld_wins   = bus.ld_req & (~w_cpu_req | (streak_q >= C_STREAK_MAX));
  assign w_in_access = (state_q == ACCESS);
  assign w_acc_last  = w_in_access & w_last;

  dmem_wait_ctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (~w_in_access | w_last),
    .inc_i  (w_in_access),
    .last_o (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= CPU;
      streak_q    <= '0;
      write_q     <= 1'b0;
      bad_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      cpu_err_q  <= 1'b0;
      ld_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_ld_wins) begin
            owner_q  <= LD;
            addr_q   <= word_align(bus.ld_addr);
            wdata_q  <= bus.ld_wdata;
            write_q  <= bus.ld_we;
            bad_q    <= 1'b0;
            streak_q <= '0;
            state_q  <= ACCESS;
          end else if (w_cpu_req) begin
            owner_q <= CPU;
            addr_q  <= word_align(bus.Address);
            wdata_q <= bus.WriteData;
            // A read+write request is carried out as a write and flagged.
            write_q <= bus.MemWrite;
            bad_q   <= (bus.MemRead & bus.MemWrite) | (bus.Address[1:0] != 2'b00);
            if (!bus.ld_req) begin
              streak_q <= '0;
            end else if (streak_q != C_STREAK_SAT) begin
              streak_q <= streak_q + 4'd1;
            end
            state_q <= ACCESS;
          end else begin
            streak_q <= '0;
          end
        end
        ACCESS: begin
          if (w_last) begin
            if (owner_q == CPU) begin
              cpu_rdata_q <= bus.mem_rdata;
              cpu_done_q  <= 1'b1;
              cpu_err_q   <= bad_q;
            end else begin
              ld_rdata_q <= bus.mem_rdata;
              ld_ack_q   <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = w_in_access;
  // Gated by rst_n so a reset landing on the final cycle never commits.
  assign bus.mem_we    = rst_n & write_q & w_acc_last;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.ReadData  = cpu_rdata_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.cpu_stall = w_cpu_req & ~cpu_done_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.ld_rdata  = ld_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_arbiter: directed and randomized self-checking bench.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dmem_arbiter;
  import mips_pkg::*;

  localparam int W3   = 3;
  localparam int MAX3 = 2;
  localparam int W0   = 0;
  localparam int LAT3 = W3 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n3;
  logic rst_n0;

  dmem_arbiter_if bus3 ();
  dmem_arbiter_if bus0 ();

  dmem_arbiter #(.WAIT_CYCLES(W3), .MAX_CPU_STREAK(MAX3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n3),
    .bus   (bus3)
  );

  dmem_arbiter #(.WAIT_CYCLES(W0), .MAX_CPU_STREAK(4)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n0),
    .bus   (bus0)
  );

  // Memory arrays seen by the two instances, plus an init port.
  logic [31:0] mem3 [0:63];
  logic [31:0] mem0 [0:63];
  logic        init_en;
  logic [5:0]  init_idx;
  logic [31:0] init_val;

  always @(posedge clk) begin
    if (init_en) begin
      mem3[init_idx] <= init_val;
      mem0[init_idx] <= init_val;
    end else begin
      if (bus3.mem_we) mem3[bus3.mem_addr[7:2]] <= bus3.mem_wdata;
      if (bus0.mem_we) mem0[bus0.mem_addr[7:2]] <= bus0.mem_wdata;
    end
  end

  assign bus3.mem_rdata = mem3[bus3.mem_addr[7:2]];
  assign bus0.mem_rdata = mem0[bus0.mem_addr[7:2]];

  // Reference model state: expected memory contents and arbitration streak.
  logic [31:0] shadow [0:63];
  int          checks = 0;
  int          errors = 0;

  int          cpu_n, code, bad, r, word, streak, win;
  logic        prev_done, prev_ack;
  logic        cpu_pend, c_rd, c_wr, ld_pend, l_we, wr, exp_err;
  logic [31:0] c_addr, c_wd, l_addr, l_wd, a, exp_rd;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu3(input logic rd, input logic wrt, input logic [31:0] ad, input logic [31:0] d);
    bus3.MemRead   = rd;
    bus3.MemWrite  = wrt;
    bus3.Address   = ad;
    bus3.WriteData = d;
  endtask

  task automatic ld3(input logic req, input logic we, input logic [31:0] ad, input logic [31:0] d);
    bus3.ld_req   = req;
    bus3.ld_we    = we;
    bus3.ld_addr  = ad;
    bus3.ld_wdata = d;
  endtask

  initial begin
    rst_n3 = 1'b0;
    rst_n0 = 1'b0;
    init_en = 1'b0;
    init_idx = '0;
    init_val = '0;
    cpu3(1'b0, 1'b0, 32'h0, 32'h0);
    ld3(1'b0, 1'b0, 32'h0, 32'h0);
    bus0.MemRead = 1'b0;  bus0.MemWrite = 1'b0;
    bus0.Address = 32'h0; bus0.WriteData = 32'h0;
    bus0.ld_req = 1'b0;   bus0.ld_we = 1'b0;
    bus0.ld_addr = 32'h0; bus0.ld_wdata = 32'h0;

    // Fill memory while both instances are held in reset.
    for (int i = 0; i < 64; i++) begin
      next();
      init_en  = 1'b1;
      init_idx = 6'(i);
      init_val = (i == 16) ? 32'hDEADBEEF : $urandom;
      shadow[i] = init_val;
    end
    next();
    init_en = 1'b0;
    mid();
    chk("rst_flags3", {bus3.mem_en, bus3.mem_we, bus3.cpu_done, bus3.cpu_err, bus3.ld_ack, bus3.cpu_stall}, 64'h0);
    chk("rst_data3", {bus3.ReadData, bus3.ld_rdata}, 64'h0);
    chk("rst_bus3", {bus3.mem_addr, bus3.mem_wdata}, 64'h0);
    chk("rst_flags0", {bus0.mem_en, bus0.mem_we, bus0.cpu_done, bus0.cpu_err, bus0.ld_ack, bus0.ReadData}, 64'h0);
    next();
    rst_n3 = 1'b1;
    rst_n0 = 1'b1;

    // Load with no wait states.
    next();
    bus0.MemRead = 1'b1;
    bus0.Address = 32'h40;
    mid();
    chk("t1_c0", {bus0.cpu_stall, bus0.mem_en, bus0.cpu_done}, 64'b100);
    next(); mid();
    chk("t1_c1", {bus0.cpu_stall, bus0.mem_en, bus0.mem_we, bus0.cpu_done}, 64'b1100);
    chk("t1_addr", bus0.mem_addr, 64'h40);
    next(); mid();
    chk("t1_c2", {bus0.cpu_stall, bus0.mem_en, bus0.cpu_done, bus0.cpu_err}, 64'b0010);
    chk("t1_rdata", bus0.ReadData, 64'hDEADBEEF);
    next();
    bus0.MemRead = 1'b0;
    mid();
    chk("t1_c3", {bus0.cpu_stall, bus0.mem_en, bus0.cpu_done}, 64'h0);

    // Store with three wait states.
    next();
    cpu3(1'b0, 1'b1, 32'h10, 32'h12345678);
    mid();
    chk("t2_c0", {bus3.cpu_stall, bus3.mem_en}, 64'b10);
    for (int k = 1; k <= W3 + 1; k++) begin
      next(); mid();
      chk("t2_access", {bus3.mem_en, bus3.mem_we, bus3.cpu_stall}, {1'b1, (k == W3 + 1), 1'b1});
    end
    next(); mid();
    chk("t2_done", {bus3.cpu_done, bus3.cpu_err, bus3.cpu_stall, bus3.mem_en}, 64'b1000);
    next();
    cpu3(1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("t2_mem", mem3[4], 64'h12345678);
    shadow[4] = 32'h12345678;

    // Fairness: three CPU loads against a held loader read.
    next();
    cpu3(1'b1, 1'b0, 32'h80, 32'h0);
    ld3(1'b1, 1'b0, 32'h8D, 32'h0);
    cpu_n = 0;
    code = 0;
    prev_done = 1'b0;
    prev_ack = 1'b0;
    for (int c = 0; c < 60 && cpu_n < 3; c++) begin
      if (c != 0) begin
        next();
        if (prev_done) cpu3(1'b1, 1'b0, 32'h80 + 32'(4 * cpu_n), 32'h0);
        if (prev_ack) ld3(1'b0, 1'b0, 32'h0, 32'h0);
      end
      mid();
      prev_done = bus3.cpu_done;
      prev_ack = bus3.ld_ack;
      if (bus3.cpu_done) begin
        chk("t3_rdata", bus3.ReadData, shadow[32 + cpu_n]);
        cpu_n++;
        code = code * 16 + 1;
      end
      if (bus3.ld_ack) begin
        chk("t3_ldata", bus3.ld_rdata, shadow[35]);
        code = code * 16 + 2;
      end
    end
    chk("t3_count", cpu_n, 64'd3);
    chk("t3_order", code, 64'h1121);
    next();
    cpu3(1'b0, 1'b0, 32'h0, 32'h0);
    ld3(1'b0, 1'b0, 32'h0, 32'h0);

    // Illegal and misaligned request.
    next();
    cpu3(1'b1, 1'b1, 32'h22, 32'hA5A50F0F);
    for (int k = 1; k <= W3 + 1; k++) begin
      next(); mid();
      if (k == W3 + 1) chk("t4_addr", {bus3.mem_we, bus3.mem_addr}, {1'b1, 32'h20});
    end
    next(); mid();
    chk("t4_done", {bus3.cpu_done, bus3.cpu_err}, 64'b11);
    next();
    cpu3(1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("t4_mem", mem3[8], 64'hA5A50F0F);
    chk("t4_err_clear", {bus3.cpu_done, bus3.cpu_err}, 64'b00);
    shadow[8] = 32'hA5A50F0F;

    // Reset lands on the final access cycle of a store.
    next();
    cpu3(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
    for (int k = 1; k <= W3; k++) next();
    next();
    rst_n3 = 1'b0;
    cpu3(1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("t5_we", {bus3.mem_en, bus3.mem_we}, 64'b10);
    next(); mid();
    chk("t5_flags", {bus3.mem_en, bus3.mem_we, bus3.cpu_done, bus3.cpu_err, bus3.ld_ack, bus3.cpu_stall}, 64'h0);
    chk("t5_data", {bus3.ReadData, bus3.ld_rdata}, 64'h0);
    chk("t5_bus", {bus3.mem_addr, bus3.mem_wdata}, 64'h0);
    chk("t5_mem", mem3[12], shadow[12]);
    next();
    rst_n3 = 1'b1;

    // Randomized traffic against the transaction-level model.
    streak = 0;
    cpu_pend = 1'b0;
    ld_pend = 1'b0;
    c_rd = 1'b0; c_wr = 1'b0; c_addr = '0; c_wd = '0;
    l_we = 1'b0; l_addr = '0; l_wd = '0;
    for (int it = 0; it < 300; it++) begin
      next();
      if (!cpu_pend && $urandom_range(0, 99) < 70) begin
        r = int'($urandom_range(0, 99));
        c_rd = (r < 45) || (r >= 85);
        c_wr = (r >= 45);
        c_addr = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0) c_addr[1:0] = 2'b00;
        c_wd = $urandom;
        cpu_pend = 1'b1;
      end
      if (!ld_pend && $urandom_range(0, 99) < 40) begin
        l_we = 1'($urandom_range(0, 1));
        l_addr = $urandom_range(0, 255);
        l_wd = $urandom;
        ld_pend = 1'b1;
      end
      cpu3(cpu_pend & c_rd, cpu_pend & c_wr, c_addr, c_wd);
      ld3(ld_pend, ld_pend & l_we, l_addr, l_wd);

      if (ld_pend && (!cpu_pend || streak >= MAX3)) win = 2;
      else if (cpu_pend) win = 1;
      else win = 0;
      if (!ld_pend || win == 2) streak = 0;
      else if (win == 1 && streak < 15) streak++;

      if (win == 0) begin
        mid();
        chk("rnd_idle", {bus3.cpu_done, bus3.ld_ack, bus3.cpu_stall, bus3.mem_en}, 64'h0);
        continue;
      end

      a = (win == 1) ? c_addr : l_addr;
      word = int'(a[7:2]);
      wr = (win == 1) ? c_wr : l_we;
      exp_rd = shadow[word];
      exp_err = (win == 1) && ((c_rd && c_wr) || (c_addr[1:0] != 2'b00));
      for (int k = 1; k <= LAT3; k++) begin
        next(); mid();
        if (k < LAT3)
          chk("rnd_busy", {bus3.cpu_done, bus3.ld_ack, bus3.cpu_stall}, {2'b00, cpu_pend});
        if (k == W3 + 1)
          chk("rnd_mem", {bus3.mem_en, bus3.mem_we, bus3.mem_addr}, {1'b1, wr, a[31:2], 2'b00});
        if (k == LAT3) begin
          if (win == 1) begin
            chk("rnd_cpu_done", {bus3.cpu_done, bus3.ld_ack, bus3.cpu_err, bus3.cpu_stall},
                {1'b1, 1'b0, exp_err, 1'b0});
            chk("rnd_cpu_rdata", bus3.ReadData, exp_rd);
          end else begin
            chk("rnd_ld_ack", {bus3.cpu_done, bus3.ld_ack, bus3.cpu_err, bus3.cpu_stall},
                {1'b0, 1'b1, 1'b0, cpu_pend});
            chk("rnd_ld_rdata", bus3.ld_rdata, exp_rd);
          end
        end
      end
      if (wr) shadow[word] = (win == 1) ? c_wd : l_wd;
      if (win == 1) cpu_pend = 1'b0;
      else ld_pend = 1'b0;
    end

    next();
    cpu3(1'b0, 1'b0, 32'h0, 32'h0);
    ld3(1'b0, 1'b0, 32'h0, 32'h0);
    next();
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem3[i] !== shadow[i]) bad++;
    end
    chk("mem_final", bad, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
